nibble_serial_subtractor: RTL and testbench

NIBBLE_SERIAL_SUBTRACTOR -- requirements
Module: nibble_serial_subtractor

---
 rtl/nibble_serial_subtractor.sv | 117 +++++++++++
 tb/tb_nibble_serial_subtractor.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/nibble_serial_subtractor.sv
// Serial WIDTH-bit subtractor: one nibble per clock through a 4-bit carry-lookahead slice.
// Define SUB_OVERFLOW_EN to add the signed-overflow output ovf.
module nibble_serial_subtractor #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             bout,
`ifdef SUB_OVERFLOW_EN
  output logic             ovf,
`endif
  output logic [WIDTH-1:0] diff
);

  localparam int NIB = WIDTH / 4;
  localparam int KW  = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [KW-1:0] LASTK = KW'(NIB - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  state_t           nextstate;
  logic [WIDTH-1:0] areg;
  logic [WIDTH-1:0] breg;
  logic [KW-1:0]    k;
  logic             c;
  logic             accept;
  logic             lastnib;

  logic [3:0] anib;
  logic [3:0] bnib;
  logic [3:0] g;
  logic [3:0] p;
  logic       c1;
  logic       c2;
  logic       c3;
  logic       c4;
  logic [3:0] s;

  assign accept  = start && (state != RUN);
  assign lastnib = (k == LASTK);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nextstate;
  end

  always_comb begin
    nextstate = state;
    case (state)
      IDLE:    if (start) nextstate = RUN;
      RUN:     if (lastnib) nextstate = DONE;
      DONE:    nextstate = start ? RUN : IDLE;
      default: nextstate = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == RUN);
    done = (state == DONE);
  end

  // Subtraction as a + ~b + c with c seeded to 1; generate/propagate lookahead for one nibble.
  always_comb begin
    anib = areg[{k, 2'b00} +: 4];
    bnib = ~breg[{k, 2'b00} +: 4];
    g    = anib & bnib;
    p    = anib ^ bnib;
    c1   = g[0] | (p[0] & c);
    c2   = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c);
    c3   = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c);
    c4   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (&p & c);
    s    = p ^ {c3, c2, c1, c};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      areg <= '0;
      breg <= '0;
      k    <= '0;
      c    <= 1'b1;
      diff <= '0;
      bout <= 1'b0;
`ifdef SUB_OVERFLOW_EN
      ovf  <= 1'b0;
`endif
    end else if (accept) begin
      areg <= a;
      breg <= b;
      k    <= '0;
      c    <= 1'b1;
      diff <= '0;
      bout <= 1'b0;
`ifdef SUB_OVERFLOW_EN
      ovf  <= 1'b0;
`endif
    end else if (state == RUN) begin
      diff[{k, 2'b00} +: 4] <= s;
      c <= c4;
      k <= k + 1'b1;
      if (lastnib) begin
        bout <= ~c4;
`ifdef SUB_OVERFLOW_EN
        // s[3] is the final sign bit of diff, not yet visible in the register.
        ovf  <= (areg[WIDTH-1] != breg[WIDTH-1]) && (s[3] != areg[WIDTH-1]);
`endif
      end
    end
  end

endmodule

// File: tb/tb_nibble_serial_subtractor.sv
// Directed self-checking bench for nibble_serial_subtractor at WIDTH=16.
// Checks ovf as well when built with SUB_OVERFLOW_EN.
module tb_nibble_serial_subtractor;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] a;
  logic [15:0] b;
  logic        busy;
  logic        done;
  logic        bout;
  logic [15:0] diff;
`ifdef SUB_OVERFLOW_EN
  logic        ovf;
`endif

  int checks;
  int fails;

  nibble_serial_subtractor #(.WIDTH(16)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .bout  (bout),
`ifdef SUB_OVERFLOW_EN
    .ovf   (ovf),
`endif
    .diff  (diff)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One start pulse, then watch latency, busy length, result, and hold after done.
  task automatic applyStimulus(input string tag, input logic [15:0] av, input logic [15:0] bv,
                               input logic [15:0] expdiff, input logic expbout,
                               input logic expovf);
    int busycnt;
    int lat;
    bit got;
    @(negedge clk);
    a = av;
    b = bv;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checkOutput({tag, ".clrdiff"}, 32'(diff), 32'h0);
    checkOutput({tag, ".clrbout"}, 32'(bout), 32'h0);
    busycnt = 0;
    lat = 99;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      if (busy) busycnt++;
      if (done) begin
        got = 1'b1;
        lat = i;
      end else begin
        @(negedge clk);
      end
    end
    checkOutput({tag, ".latency"}, 32'(lat), 32'd4);
    checkOutput({tag, ".busycycles"}, 32'(busycnt), 32'd4);
    checkOutput({tag, ".diff"}, 32'(diff), 32'(expdiff));
    checkOutput({tag, ".bout"}, 32'(bout), 32'(expbout));
`ifdef SUB_OVERFLOW_EN
    checkOutput({tag, ".ovf"}, 32'(ovf), 32'(expovf));
`else
    if (expovf) begin end
`endif
    @(negedge clk);
    checkOutput({tag, ".donepulse"}, 32'(done), 32'h0);
    checkOutput({tag, ".hold"}, 32'(diff), 32'(expdiff));
  endtask

  initial begin
    int donecnt;
    int doneat[2];
    checks = 0;
    fails = 0;
    rst = 1'b1;
    start = 1'b0;
    a = '0;
    b = '0;
    #12;
    checkOutput("reset.busy", 32'(busy), 32'h0);
    checkOutput("reset.done", 32'(done), 32'h0);
    checkOutput("reset.diff", 32'(diff), 32'h0);
    checkOutput("reset.bout", 32'(bout), 32'h0);
    @(negedge clk);
    rst = 1'b0;

    applyStimulus("basic", 16'h1234, 16'h0234, 16'h1000, 1'b0, 1'b0);
    applyStimulus("under", 16'h0000, 16'h0001, 16'hFFFF, 1'b1, 1'b0);
    applyStimulus("sovf",  16'h8000, 16'h0001, 16'h7FFF, 1'b0, 1'b1);
    applyStimulus("negov", 16'h0001, 16'h8000, 16'h8001, 1'b1, 1'b1);
    applyStimulus("equal", 16'hABCD, 16'hABCD, 16'h0000, 1'b0, 1'b0);
    applyStimulus("chain", 16'h1000, 16'h0001, 16'h0FFF, 1'b0, 1'b0);

    // Start held for ten edges: two back-to-back results, operand noise during RUN.
    @(negedge clk);
    a = 16'h00FF;
    b = 16'h000F;
    start = 1'b1;
    donecnt = 0;
    doneat[0] = -1;
    doneat[1] = -1;
    for (int cyc = 0; cyc < 10; cyc++) begin
      @(negedge clk);
      if (done) begin
        if (donecnt < 2) doneat[donecnt] = cyc;
        donecnt++;
        checkOutput("b2b.diff", 32'(diff), 32'h00F0);
        checkOutput("b2b.bout", 32'(bout), 32'h0);
      end
      if (cyc == 0 || cyc == 5) begin
        a = 16'hDEAD;
        b = 16'hBEEF;
      end
      if (cyc == 4) begin
        a = 16'h00FF;
        b = 16'h000F;
      end
    end
    start = 1'b0;
    checkOutput("b2b.count", 32'(donecnt), 32'd2);
    checkOutput("b2b.first", 32'(doneat[0]), 32'd4);
    checkOutput("b2b.second", 32'(doneat[1]), 32'd9);
    @(negedge clk);
    checkOutput("b2b.idle", 32'(busy | done), 32'h0);

    // Reset in the second RUN cycle aborts the operation without a done pulse.
    @(negedge clk);
    a = 16'h1234;
    b = 16'h0001;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("abort.busy", 32'(busy), 32'h0);
    checkOutput("abort.done", 32'(done), 32'h0);
    checkOutput("abort.diff", 32'(diff), 32'h0);
    checkOutput("abort.bout", 32'(bout), 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    donecnt = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (done || busy) donecnt++;
    end
    checkOutput("abort.quiet", 32'(donecnt), 32'h0);
    applyStimulus("fresh", 16'h0005, 16'h0007, 16'hFFFE, 1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
